// File: rtl/instr_line_fill_responder_pkg.sv
// Shared constants and fill-state encoding for the instruction-memory line refill path.
package icache_mem_pkg;

  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 8;
  localparam int LINE_W         = 256;
  localparam int BEAT_W         = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4,
    GAP   = 3'd5
  } fill_state_e;

endpackage

// File: rtl/instr_line_fill_responder_if.sv
// Cache-side request/response bus plus the word-RAM read port of the line fill responder.
interface instr_line_fill_responder_if #(
  parameter int RAM_ADDR_W = 20
);
  import icache_mem_pkg::*;

  logic                  mem_req;
  logic [31:0]           mem_address;
  logic [LINE_W-1:0]     mem_data;
  logic                  mem_valid;
  logic                  busy;
  logic                  ram_rd_en;
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0]     ram_rdata;

  modport slave (
    input  mem_req, mem_address, ram_rdata,
    output mem_data, mem_valid, busy, ram_rd_en, ram_addr
  );

  modport master (
    output mem_req, mem_address, ram_rdata,
    input  mem_data, mem_valid, busy, ram_rd_en, ram_addr
  );

endinterface

// File: rtl/instr_line_fill_responder.sv
// Memory-side responder: waits MEM_LATENCY cycles, reads 8 RAM words, returns one 256-bit line.
// Optional last-line buffer enabled by defining ICACHE_LINE_BUFFER_EN.
module instr_line_fill_responder
  import icache_mem_pkg::*;
#(
  parameter int MEM_LATENCY = 10,
  parameter int RAM_ADDR_W  = 20
) (
  input logic                     CLK,
  input logic                     RESET,
  instr_line_fill_responder_if.slave bus
);

  localparam int LINE_ADDR_W = RAM_ADDR_W - BEAT_W;
  localparam int LAT_W       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);

  fill_state_e            state_r;
  logic [LINE_ADDR_W-1:0] line_addr_r;
  logic [LAT_W-1:0]       lat_cnt_r;
  logic [BEAT_W-1:0]      beat_r;
  logic                   ram_rd_en_r;
  logic [RAM_ADDR_W-1:0]  ram_addr_r;
  logic                   mem_valid_r;
  logic                   busy_r;
  logic [LINE_W-1:0]      mem_data_r;
  logic                   cap_en_r;
  logic [BEAT_W-1:0]      cap_beat_r;
  logic [LINE_ADDR_W-1:0] req_line_s;
  logic                   hit_s;

  assign req_line_s = bus.mem_address[RAM_ADDR_W-1:BEAT_W];

`ifdef ICACHE_LINE_BUFFER_EN
  logic                   buf_valid_r;
  logic [LINE_ADDR_W-1:0] buf_tag_r;

  assign hit_s = buf_valid_r && (buf_tag_r == req_line_s);

  // Remember which line the most recent response carried.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      buf_valid_r <= 1'b0;
      buf_tag_r   <= {LINE_ADDR_W{1'b0}};
    end else if (state_r == RESP) begin
      buf_valid_r <= 1'b1;
      buf_tag_r   <= line_addr_r;
    end
  end
`else
  assign hit_s = 1'b0;
`endif

  // Fill sequencer: counters and all bus outputs are registered here.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r     <= IDLE;
      line_addr_r <= {LINE_ADDR_W{1'b0}};
      lat_cnt_r   <= {LAT_W{1'b0}};
      beat_r      <= {BEAT_W{1'b0}};
      ram_rd_en_r <= 1'b0;
      ram_addr_r  <= {RAM_ADDR_W{1'b0}};
      mem_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.mem_req) begin
            line_addr_r <= req_line_s;
            busy_r      <= 1'b1;
            if (hit_s) begin
              state_r     <= RESP;
              mem_valid_r <= 1'b1;
            end else if (MEM_LATENCY == 0) begin
              state_r     <= READ;
              ram_rd_en_r <= 1'b1;
              ram_addr_r  <= {req_line_s, {BEAT_W{1'b0}}};
              beat_r      <= {BEAT_W{1'b0}};
            end else begin
              state_r   <= WAIT;
              lat_cnt_r <= LAT_LOAD;
            end
          end
        end
        WAIT: begin
          if (lat_cnt_r == {LAT_W{1'b0}}) begin
            state_r     <= READ;
            ram_rd_en_r <= 1'b1;
            ram_addr_r  <= {line_addr_r, {BEAT_W{1'b0}}};
            beat_r      <= {BEAT_W{1'b0}};
          end else begin
            lat_cnt_r <= lat_cnt_r - {{(LAT_W-1){1'b0}}, 1'b1};
          end
        end
        READ: begin
          if (beat_r == 3'd7) begin
            state_r     <= DRAIN;
            ram_rd_en_r <= 1'b0;
            beat_r      <= {BEAT_W{1'b0}};
          end else begin
            beat_r     <= beat_r + 3'd1;
            ram_addr_r <= {line_addr_r, beat_r + 3'd1};
          end
        end
        DRAIN: begin
          state_r     <= RESP;
          mem_valid_r <= 1'b1;
        end
        RESP: begin
          state_r     <= GAP;
          mem_valid_r <= 1'b0;
        end
        GAP: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          ram_rd_en_r <= 1'b0;
          mem_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // RAM data trails its strobe by one cycle, so capture follows a delayed copy of the strobe.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cap_en_r   <= 1'b0;
      cap_beat_r <= {BEAT_W{1'b0}};
      mem_data_r <= {LINE_W{1'b0}};
    end else begin
      cap_en_r   <= ram_rd_en_r;
      cap_beat_r <= ram_addr_r[BEAT_W-1:0];
      if (cap_en_r) begin
        mem_data_r[int'(cap_beat_r)*WORD_W +: WORD_W] <= bus.ram_rdata;
      end
    end
  end

  assign bus.mem_data  = mem_data_r;
  assign bus.mem_valid = mem_valid_r;
  assign bus.busy      = busy_r;
  assign bus.ram_rd_en = ram_rd_en_r;
  assign bus.ram_addr  = ram_addr_r;

endmodule

// File: tb/tb_instr_line_fill_responder.sv
// Directed bench: one responder with MEM_LATENCY=10 and one with MEM_LATENCY=0, each with a RAM model.
module tb_instr_line_fill_responder;
  import icache_mem_pkg::*;

  logic CLK = 1'b0;
  logic rst_a;
  logic rst_b;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   c0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  instr_line_fill_responder_if #(.RAM_ADDR_W(20)) a_if ();
  instr_line_fill_responder_if #(.RAM_ADDR_W(20)) b_if ();

  instr_line_fill_responder #(.MEM_LATENCY(10), .RAM_ADDR_W(20)) dut_a (
    .CLK(CLK), .RESET(rst_a), .bus(a_if.slave)
  );
  instr_line_fill_responder #(.MEM_LATENCY(0), .RAM_ADDR_W(20)) dut_b (
    .CLK(CLK), .RESET(rst_b), .bus(b_if.slave)
  );

  // RAM models: word at address a holds A000_0000 | a.
  always @(posedge CLK) if (a_if.ram_rd_en) a_if.ram_rdata <= 32'hA000_0000 | {12'h000, a_if.ram_addr};
  always @(posedge CLK) if (b_if.ram_rd_en) b_if.ram_rdata <= 32'hA000_0000 | {12'h000, b_if.ram_addr};

  int           a_rd_cyc[$];
  logic [19:0]  a_rd_addr[$];
  int           a_vld_cyc[$];
  logic [255:0] a_vld_data[$];
  int           b_rd_cyc[$];
  int           b_vld_cyc[$];
  logic [255:0] b_vld_data[$];

  // Record read strobes and response pulses mid-cycle.
  always @(negedge CLK) begin
    if (a_if.ram_rd_en) begin a_rd_cyc.push_back(cyc); a_rd_addr.push_back(a_if.ram_addr); end
    if (a_if.mem_valid) begin a_vld_cyc.push_back(cyc); a_vld_data.push_back(a_if.mem_data); end
    if (b_if.ram_rd_en) b_rd_cyc.push_back(cyc);
    if (b_if.mem_valid) begin b_vld_cyc.push_back(cyc); b_vld_data.push_back(b_if.mem_data); end
  end

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] line_of(input logic [19:0] base);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = 32'hA000_0000 | {12'h000, base[19:3], 3'(k)};
    return r;
  endfunction

  task automatic clr_q();
    a_rd_cyc.delete(); a_rd_addr.delete(); a_vld_cyc.delete(); a_vld_data.delete();
    b_rd_cyc.delete(); b_vld_cyc.delete(); b_vld_data.delete();
  endtask

  task automatic start_a(input logic [31:0] addr, output int s);
    @(posedge CLK); #1;
    s = cyc;
    a_if.mem_req     = 1'b1;
    a_if.mem_address = addr;
    @(posedge CLK); #1;
    a_if.mem_req = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin @(posedge CLK); #1; end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    a_if.mem_req = 1'b0; a_if.mem_address = 32'h0;
    b_if.mem_req = 1'b0; b_if.mem_address = 32'h0;
    repeat (3) @(posedge CLK);
    #1;
    check_val("rst_valid", 256'(a_if.mem_valid), 256'd0);
    check_val("rst_busy",  256'(a_if.busy),      256'd0);
    check_val("rst_rd_en", 256'(a_if.ram_rd_en), 256'd0);
    check_val("rst_addr",  256'(a_if.ram_addr),  256'd0);
    check_val("rst_data",  a_if.mem_data,        256'd0);
    @(negedge CLK); rst_a = 1'b0; rst_b = 1'b0;

    // Both responders get line 0x40; A is reset during beat 4, B (zero latency) completes.
    clr_q();
    @(posedge CLK); #1;
    c0 = cyc;
    a_if.mem_req = 1'b1; a_if.mem_address = 32'h40;
    b_if.mem_req = 1'b1; b_if.mem_address = 32'h40;
    @(posedge CLK); #1;
    a_if.mem_req = 1'b0; b_if.mem_req = 1'b0;
    wait_until(c0 + 15);
    @(negedge CLK); #1;
    check_val("abort_beat4_addr", 256'(a_if.ram_addr), 256'h44);
    rst_a = 1'b1; #1;
    check_val("abort_rd_en", 256'(a_if.ram_rd_en), 256'd0);
    check_val("abort_busy",  256'(a_if.busy),      256'd0);
    check_val("abort_valid", 256'(a_if.mem_valid), 256'd0);
    check_val("abort_data",  a_if.mem_data,        256'd0);
    check_val("lat0_rd_count", 256'(b_rd_cyc.size()), 256'd8);
    check_val("lat0_rd_first", 256'(b_rd_cyc[0]), 256'(c0 + 1));
    check_val("lat0_rd_last",  256'(b_rd_cyc[7]), 256'(c0 + 8));
    check_val("lat0_vld_count", 256'(b_vld_cyc.size()), 256'd1);
    check_val("lat0_vld_cyc",  256'(b_vld_cyc[0]), 256'(c0 + 10));
    check_val("lat0_data",     b_vld_data[0], line_of(20'h40));
    @(negedge CLK); rst_a = 1'b0;
    clr_q();
    repeat (25) @(posedge CLK);
    check_val("abort_no_resp", 256'(a_vld_cyc.size()), 256'd0);

    // Full fill of line 0x40 with latency 10.
    clr_q();
    start_a(32'h40, c0);
    wait_until(c0 + 26);
    check_val("fill_rd_count", 256'(a_rd_cyc.size()), 256'd8);
    for (int k = 0; k < 8; k++) begin
      check_val($sformatf("fill_rd_addr%0d", k), 256'(a_rd_addr[k]), 256'(20'h40 + 20'(k)));
      check_val($sformatf("fill_rd_cyc%0d", k),  256'(a_rd_cyc[k]),  256'(c0 + 11 + k));
    end
    check_val("fill_vld_count", 256'(a_vld_cyc.size()), 256'd1);
    check_val("fill_vld_cyc",   256'(a_vld_cyc[0]), 256'(c0 + 20));
    check_val("fill_word0", 256'(a_vld_data[0][31:0]),    256'(32'hA000_0040));
    check_val("fill_word7", 256'(a_vld_data[0][255:224]), 256'(32'hA000_0047));
    check_val("fill_line",  a_vld_data[0], line_of(20'h40));

    // Repeat request for the same line.
    clr_q();
    start_a(32'h40, c0);
    wait_until(c0 + 26);
    check_val("repeat_vld_count", 256'(a_vld_cyc.size()), 256'd1);
    check_val("repeat_data", a_vld_data[0], line_of(20'h40));
`ifdef ICACHE_LINE_BUFFER_EN
    check_val("repeat_vld_cyc",  256'(a_vld_cyc[0]), 256'(c0 + 1));
    check_val("repeat_rd_count", 256'(a_rd_cyc.size()), 256'd0);
`else
    check_val("repeat_vld_cyc",  256'(a_vld_cyc[0]), 256'(c0 + 20));
    check_val("repeat_rd_count", 256'(a_rd_cyc.size()), 256'd8);
`endif

    @(negedge CLK); rst_a = 1'b1;
    @(negedge CLK); rst_a = 1'b0;

    // Address moves to 0x80 in c3 with the request held: 0x40 served first, 0x80 next.
    clr_q();
    @(posedge CLK); #1;
    c0 = cyc;
    a_if.mem_req = 1'b1; a_if.mem_address = 32'h40;
    wait_until(c0 + 3);
    a_if.mem_address = 32'h80;
    wait_until(c0 + 23);
    a_if.mem_req = 1'b0;
    while (a_vld_cyc.size() < 2 && cyc < c0 + 70) begin @(posedge CLK); #1; end
    check_val("switch_vld_count", 256'(a_vld_cyc.size()), 256'd2);
    check_val("switch_vld0_cyc",  256'(a_vld_cyc[0]), 256'(c0 + 20));
    check_val("switch_line0",     a_vld_data[0], line_of(20'h40));
    check_val("switch_spacing",   256'(a_vld_cyc[1] - a_vld_cyc[0]), 256'd22);
    check_val("switch_line1",     a_vld_data[1], line_of(20'h80));
    check_val("switch_rd_count",  256'(a_rd_cyc.size()), 256'd16);
    check_val("switch_rd8",       256'(a_rd_addr[8]),  256'h80);
    check_val("switch_rd15",      256'(a_rd_addr[15]), 256'h87);
    repeat (4) @(posedge CLK);

    // High address bits and low offset bits are ignored.
    clr_q();
    start_a(32'hC000_0043, c0);
    wait_until(c0 + 26);
    check_val("alias_rd_count", 256'(a_rd_cyc.size()), 256'd8);
    check_val("alias_rd_first", 256'(a_rd_addr[0]), 256'h40);
    check_val("alias_rd_last",  256'(a_rd_addr[7]), 256'h47);
    check_val("alias_vld_cyc",  256'(a_vld_cyc[0]), 256'(c0 + 20));
    check_val("alias_line",     a_vld_data[0], line_of(20'h40));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
